// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_BAUD   = 2'd2;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    localparam logic [3:0] UART_REGION = 4'h8;

endpackage

// File: rtl/uart_tx_slave_if.sv
// Data-bus slice seen by the UART region responder.
interface uart_tx_slave_if;

    logic        sel;
    logic        wr;
    logic [3:0]  addr;
    logic [3:0]  mask;
    logic [31:0] data_wr;
    logic [31:0] data_rd;

    modport master (
        output sel, wr, addr, mask, data_wr,
        input  data_rd
    );

    modport slave (
        input  sel, wr, addr, mask, data_wr,
        output data_rd
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with a combinational head; push is ignored when full.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_slave.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, status and baud registers.
// Define UART_TX_PARITY_EN to append an even-parity bit before the stop bit.
module uart_tx_slave
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] BAUD_DIV_RST = 16'd868
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_slave_if.slave  bus,
    output logic            tx,
    output logic            tx_busy
);

    tx_state_t   state, state_n;
    logic [7:0]  shift, shift_n;
    logic [2:0]  bit_idx, bit_n;
    logic [15:0] baud_cnt, cnt_n;
    logic [15:0] div_lat, div_n;
    logic [15:0] baud_div;
    logic        overflow;
    logic        bit_end;
    logic        pop;
    logic        ld;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [1:0]  reg_a;
    logic        wr_en;
    logic        push_req;
    logic        ovf_clr;
    logic        baud_we;
    logic        unused_bus;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_n;
`endif

    assign reg_a    = bus.addr[3:2];
    assign wr_en    = bus.sel & bus.wr;
    assign push_req = wr_en & (reg_a == UART_TXDATA) & bus.mask[0];
    assign ovf_clr  = wr_en & (reg_a == UART_STATUS)
                    & bus.mask[0] & bus.data_wr[3];
    assign baud_we  = wr_en & (reg_a == UART_BAUD)
                    & (bus.mask[1:0] == 2'b11);
    assign unused_bus = ^{bus.addr[1:0], bus.mask[3:2],
                          bus.data_wr[31:16]};

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (pop),
        .din   (bus.data_wr[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_busy = (state != IDLE) | ~fifo_empty;
    assign bit_end = (baud_cnt == div_lat - 16'd1);

    always_comb begin
        bus.data_rd = '0;
        if (bus.sel) begin
            case (reg_a)
                UART_STATUS: begin
                    bus.data_rd[ST_FULL]  = fifo_full;
                    bus.data_rd[ST_EMPTY] = fifo_empty;
                    bus.data_rd[ST_BUSY]  = tx_busy;
                    bus.data_rd[ST_OVF]   = overflow;
                end
                UART_BAUD: bus.data_rd[15:0] = baud_div;
                default:   bus.data_rd = '0;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        shift_n = shift;
        bit_n   = bit_idx;
        cnt_n   = baud_cnt;
        div_n   = div_lat;
        pop     = 1'b0;
        ld      = 1'b0;
        tx      = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_n   = par_q;
`endif
        if (state != IDLE) cnt_n = bit_end ? 16'd0 : baud_cnt + 16'd1;
        case (state)
            IDLE: begin
                if (!fifo_empty) ld = 1'b1;
            end
            START: begin
                tx = 1'b0;
                if (bit_end) begin
                    state_n = DATA;
                    bit_n   = 3'd0;
                end
            end
            DATA: begin
                tx = shift[0];
                if (bit_end) begin
                    shift_n = shift >> 1;
                    bit_n   = bit_idx + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (bit_idx == 3'd7) state_n = PARITY;
`else
                    if (bit_idx == 3'd7) state_n = STOP;
`endif
                end
            end
            PARITY: begin
`ifdef UART_TX_PARITY_EN
                tx = par_q;
                if (bit_end) state_n = STOP;
`else
                state_n = IDLE;
`endif
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) ld = 1'b1;
                    else             state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Shared frame load for IDLE and back-to-back from STOP
        if (ld) begin
            pop     = 1'b1;
            state_n = START;
            shift_n = fifo_dout;
            bit_n   = 3'd0;
            cnt_n   = 16'd0;
            div_n   = (baud_div == 16'd0) ? 16'd1 : baud_div;
`ifdef UART_TX_PARITY_EN
            par_n   = ^fifo_dout;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            div_lat  <= 16'd1;
            baud_div <= BAUD_DIV_RST;
            overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            bit_idx  <= bit_n;
            baud_cnt <= cnt_n;
            div_lat  <= div_n;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_n;
`endif
            if (baud_we) baud_div <= bus.data_wr[15:0];
            if (push_req & fifo_full) overflow <= 1'b1;
            else if (ovf_clr)         overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_slave.sv
// Scoreboard bench: stimulus queues expected bytes, a line monitor decodes frames.
module tb_uart_tx_slave;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct {
        logic [7:0] data;
        bit         b2b;
    } exp_t;

    logic clk;
    logic rst_n;
    logic tx;
    logic tx_busy;
    int   n_checks;
    int   n_errors;
    int   cur_div;
    int   starts_seen;
    exp_t exp_q[$];

    uart_tx_slave_if bus ();

    uart_tx_slave #(
        .FIFO_DEPTH   (8),
        .BAUD_DIV_RST (16'd868)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [3:0] m,
                          input logic [31:0] d);
        bus.sel = 1'b1;
        bus.wr = 1'b1;
        bus.addr = a;
        bus.mask = m;
        bus.data_wr = d;
        @(posedge clk);
        #1;
        bus.sel = 1'b0;
        bus.wr = 1'b0;
        bus.mask = 4'h0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        bus.sel = 1'b1;
        bus.wr = 1'b0;
        bus.addr = a;
        bus.mask = 4'h0;
        #1;
        v = bus.data_rd;
        bus.sel = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit b2b);
        exp_t e;
        e.data = b;
        e.b2b = b2b;
        exp_q.push_back(e);
        wr_reg(4'h0, 4'b0001, {24'h0, b});
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 3000) begin
            @(posedge clk);
            i++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Line monitor: every bit must hold for exactly cur_div cycles
    initial begin : monitor
        int gap;
        int g;
        int d;
        bit ok_w;
        bit abort;
        logic [NB-1:0] bits;
        exp_t e;
        gap = 1000;
        starts_seen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gap = 1000;
                continue;
            end
            if (tx !== 1'b0) begin
                gap++;
                continue;
            end
            starts_seen++;
            g = gap;
            d = cur_div;
            ok_w = 1'b1;
            abort = 1'b0;
            bits = '0;
            for (int b = 0; b < NB && !abort; b++) begin
                for (int c = 0; c < d && !abort; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (!rst_n) abort = 1'b1;
                    else if (c == 0) bits[b] = tx;
                    else if (tx !== bits[b]) ok_w = 1'b0;
                end
            end
            if (abort) begin
                gap = 1000;
                continue;
            end
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", {{(32-NB){1'b0}}, bits}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("frame_data", bits[8:1], e.data);
                chk("frame_stop", bits[NB-1], 1);
                chk("bit_width", ok_w, 1);
`ifdef UART_TX_PARITY_EN
                chk("frame_parity", bits[9], ^e.data);
`endif
                if (e.b2b) chk("b2b_gap", g, 0);
            end
            gap = 0;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] v;
        int s0;
        n_checks = 0;
        n_errors = 0;
        cur_div = 868;
        bus.sel = 1'b0;
        bus.wr = 1'b0;
        bus.addr = 4'h0;
        bus.mask = 4'h0;
        bus.data_wr = 32'h0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        rd(4'h4, v);
        chk("rst_status", v, 32'h2);
        rd(4'h8, v);
        chk("rst_baud", v, 32'd868);

        wr_reg(4'h8, 4'b0011, 32'd4);
        cur_div = 4;
        rd(4'h8, v);
        chk("baud_set", v, 32'd4);

        // Single byte with exact start latency and busy duration
        @(posedge clk);
        #1;
        send(8'hA5, 1'b0);
        chk("sb_tx_write_edge", tx, 1);
        chk("sb_busy", tx_busy, 1);
        @(posedge clk);
        #1;
        chk("sb_start", tx, 0);
        repeat (NB * 4 - 1) @(posedge clk);
        #1;
        chk("sb_busy_last", tx_busy, 1);
        @(posedge clk);
        #1;
        chk("sb_busy_end", tx_busy, 0);
        chk("sb_tx_idle", tx, 1);
        drain();

        send(8'h07, 1'b0);
        drain();

        send(8'h00, 1'b0);
        send(8'hFF, 1'b1);
        drain();

        wr_reg(4'h0, 4'b0010, 32'h0000_3300);
        repeat (3) @(posedge clk);
        #1;
        rd(4'h4, v);
        chk("masked_txdata", v, 32'h2);
        wr_reg(4'h8, 4'b0001, 32'd9);
        wr_reg(4'hC, 4'hF, 32'h1234);
        rd(4'h8, v);
        chk("masked_baud", v, 32'd4);
        rd(4'hC, v);
        chk("rsvd_read", v, 0);
        rd(4'h0, v);
        chk("txdata_read", v, 0);
        bus.addr = 4'h8;
        bus.sel = 1'b0;
        #1;
        chk("nosel_read", bus.data_rd, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            if (i < 9) begin
                exp_t e;
                e.data = 8'h10 + 8'(i);
                e.b2b = (i != 0);
                exp_q.push_back(e);
            end
            wr_reg(4'h0, 4'b0001, 32'h10 + i);
        end
        rd(4'h4, v);
        chk("ovf_status", v, 32'hD);
        wr_reg(4'h4, 4'b0001, 32'h8);
        rd(4'h4, v);
        chk("ovf_clear", v, 32'h5);
        drain();

        // Reset during data bit 3 with a second byte still queued
        send(8'h55, 1'b0);
        wr_reg(4'h0, 4'b0001, 32'h66);
        repeat (17) @(posedge clk);
        #1;
        chk("mid_tx_data", tx, 1'b0 ^ 8'h55 >> 3 & 1);
        rst_n = 1'b0;
        exp_q.delete();
        cur_div = 868;
        @(posedge clk);
        #1;
        chk("mid_rst_tx", tx, 1);
        rd(4'h4, v);
        chk("mid_rst_status", v, 32'h2);
        rst_n = 1'b1;
        s0 = starts_seen;
        rd(4'h8, v);
        chk("mid_rst_baud", v, 32'd868);
        repeat (100) @(posedge clk);
        #1;
        chk("mid_no_frame", starts_seen - s0, 0);
        chk("mid_idle_busy", tx_busy, 0);
        chk("final_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
